// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: access size codes, data-memory FSM states and
// byte-lane ordering helpers used by the memory stage.
package riscv_pkg;

    localparam logic [1:0] LP_SIZE_B = 2'b00;
    localparam logic [1:0] LP_SIZE_H = 2'b01;
    localparam logic [1:0] LP_SIZE_W = 2'b10;

    localparam bit LP_LITTLE_ENDIAN = 1'b0;
    localparam bit LP_BIG_ENDIAN    = 1'b1;

    typedef enum logic {IDLE, SPLIT} dmem_state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            LP_SIZE_B: return 3'd1;
            LP_SIZE_H: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

    // Byte slot (bits [8*slot+7:8*slot]) that holds byte offset 'lane' of a word.
    function automatic logic [1:0] lane_slot(input bit big_endian, input logic [1:0] lane);
        return big_endian ? ~lane : lane;
    endfunction

endpackage

// File: rtl/riscv_dmem_lane_align.sv
// Byte-lane steering for one beat of a data-memory access: byte enables, lane-placed
// store data, and this beat's bytes of the read word rebased to offset 0.
module riscv_dmem_lane_align
    import riscv_pkg::*;
#(
    parameter bit MP_ENDIANESS = LP_BIG_ENDIAN
) (
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        second_beat,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_lanes,
    output logic [31:0] rd_part
);

    logic [2:0] nbytes;
    logic [2:0] pos    [4];
    logic [1:0] vsel   [4];
    logic [1:0] slot_m [4];
    logic [1:0] slot_r [4];

    assign nbytes = size_bytes(size);

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            pos[p]    = {1'b0, offset} + 3'(p);
            // Big-endian puts the most significant data byte at the lowest address.
            vsel[p]   = MP_ENDIANESS ? 2'(nbytes - 3'(p) - 3'd1) : 2'(p);
            slot_m[p] = lane_slot(MP_ENDIANESS, pos[p][1:0]);
            slot_r[p] = lane_slot(MP_ENDIANESS, 2'(p));
        end
    end

    always_comb begin
        byte_en  = '0;
        wr_lanes = '0;
        rd_part  = '0;
        for (int p = 0; p < 4; p++) begin
            if (3'(p) < nbytes && pos[p][2] == second_beat) begin
                byte_en[slot_m[p]]               = 1'b1;
                wr_lanes[{slot_m[p], 3'b000} +: 8] = wr_data[{vsel[p], 3'b000} +: 8];
                rd_part[{slot_r[p], 3'b000} +: 8]  = rd_word[{slot_m[p], 3'b000} +: 8];
            end
        end
        if (size == LP_SIZE_B) begin
            wr_lanes = {4{wr_data[7:0]}};
        end
    end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory responder for the memory stage (B/H/W loads and stores on a word array).
// Define RISCV_DMEM_MISALIGN_EN to split misaligned accesses into two stalled beats.
module riscv_dmem_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned MP_DATA_WIDTH  = 32,
    parameter int unsigned MP_ADDR_WIDTH  = 32,
    parameter int unsigned MP_DEPTH_WORDS = 1024,
    parameter bit          MP_ENDIANESS   = LP_BIG_ENDIAN
) (
    input  logic                     iclk,
    input  logic                     irst_n,
    input  logic                     ivalid,
    input  logic                     iwr_en,
    input  logic [MP_ADDR_WIDTH-1:0] iaddr,
    input  logic [2:0]               ifunct3,
    input  logic [MP_DATA_WIDTH-1:0] iwr_data,
    output logic [MP_DATA_WIDTH-1:0] ord_data,
    output logic                     ostall,
    output logic                     omisaligned
);

    localparam int unsigned LP_IDX_W = $clog2(MP_DEPTH_WORDS);

    logic [MP_DATA_WIDTH-1:0] mem [MP_DEPTH_WORDS];

    logic [LP_IDX_W-1:0] idx;
    logic [LP_IDX_W-1:0] wr_idx;
    logic [1:0]          size;
    logic                active;
    logic                misaligned;
    logic                wr_go;
    logic [3:0]          be0;
    logic [3:0]          wr_be;
    logic [31:0]         wr_lanes0;
    logic [31:0]         wr_word;
    logic [31:0]         rd_part0;
    logic                unused_bits;

    assign idx    = iaddr[LP_IDX_W+1:2];
    assign size   = (ifunct3[1:0] == 2'b11) ? LP_SIZE_W : ifunct3[1:0];
    // No access is accepted while reset is held, so an aborted split cannot restart.
    assign active = ivalid & irst_n;
    assign misaligned = (size == LP_SIZE_H && iaddr[0]) ||
                        (size == LP_SIZE_W && iaddr[1:0] != 2'b00);

    riscv_dmem_lane_align #(
        .MP_ENDIANESS (MP_ENDIANESS)
    ) u_align0 (
        .size        (size),
        .offset      (iaddr[1:0]),
        .second_beat (1'b0),
        .wr_data     (iwr_data),
        .rd_word     (mem[idx]),
        .byte_en     (be0),
        .wr_lanes    (wr_lanes0),
        .rd_part     (rd_part0)
    );

`ifdef RISCV_DMEM_MISALIGN_EN
    logic [LP_IDX_W-1:0] idx_next;
    logic [3:0]          be1;
    logic [31:0]         wr_lanes1;
    logic [31:0]         rd_part1;
    logic [31:0]         hold_q;
    dmem_state_e         state_q;
    dmem_state_e         state_d;

    assign idx_next    = idx + LP_IDX_W'(1);
    assign unused_bits = ^{iaddr[MP_ADDR_WIDTH-1:LP_IDX_W+2], ifunct3[2]};

    riscv_dmem_lane_align #(
        .MP_ENDIANESS (MP_ENDIANESS)
    ) u_align1 (
        .size        (size),
        .offset      (iaddr[1:0]),
        .second_beat (1'b1),
        .wr_data     (iwr_data),
        .rd_word     (mem[idx_next]),
        .byte_en     (be1),
        .wr_lanes    (wr_lanes1),
        .rd_part     (rd_part1)
    );

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == SPLIT && !iwr_en) begin
                hold_q <= rd_part0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ostall      = 1'b0;
        omisaligned = 1'b0;
        wr_go       = 1'b0;
        wr_idx      = idx;
        wr_be       = be0;
        wr_word     = wr_lanes0;
        ord_data    = mem[idx];
        case (state_q)
            IDLE: begin
                omisaligned = active && misaligned;
                wr_go       = active && iwr_en;
                if (active && misaligned) begin
                    state_d = SPLIT;
                    ostall  = 1'b1;
                end
            end
            SPLIT: begin
                state_d  = IDLE;
                wr_go    = active && iwr_en;
                wr_idx   = idx_next;
                wr_be    = be1;
                wr_word  = wr_lanes1;
                ord_data = hold_q | rd_part1;
            end
        endcase
    end
`else
    assign unused_bits = ^{iaddr[MP_ADDR_WIDTH-1:LP_IDX_W+2], ifunct3[2], rd_part0};

    always_comb begin
        ostall      = 1'b0;
        omisaligned = active && misaligned;
        wr_go       = active && iwr_en && !misaligned;
        wr_idx      = idx;
        wr_be       = be0;
        wr_word     = wr_lanes0;
        ord_data    = mem[idx];
    end
`endif

    always_ff @(posedge iclk) begin
        if (wr_go) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Bench for riscv_dmem_ctrl: little- and big-endian instances share stimulus and are
// checked every cycle against a byte-addressed memory model, plus literal spot values.
module tb_riscv_dmem_ctrl;
    import riscv_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned NB    = 4 * DEPTH;
`ifdef RISCV_DMEM_MISALIGN_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        iclk     = 1'b0;
    logic        irst_n   = 1'b0;
    logic        ivalid   = 1'b0;
    logic        iwr_en   = 1'b0;
    logic [31:0] iaddr    = '0;
    logic [2:0]  ifunct3  = 3'b010;
    logic [31:0] iwr_data = '0;
    logic [31:0] rd_le, rd_be;
    logic        stall_le, stall_be, mis_le, mis_be;

    int n_vec = 0;
    int n_err = 0;

    // Model: plain byte memory per endianness (stored byte order differs by endianness).
    logic [7:0] mb    [2][NB];
    bit         known [2][NB];
    bit         second_beat = 1'b0;

    logic [31:0] fb_rd [2];
    logic [31:0] sb_rd [2];
    logic        fb_stall [2];
    logic        fb_mis [2];
    logic [31:0] pa [2];
    logic [31:0] pb [2];
    logic        ab_stall [2];

    always #5 iclk = ~iclk;

    riscv_dmem_ctrl #(
        .MP_DATA_WIDTH  (32),
        .MP_ADDR_WIDTH  (32),
        .MP_DEPTH_WORDS (DEPTH),
        .MP_ENDIANESS   (LP_LITTLE_ENDIAN)
    ) dut_le (
        .iclk        (iclk),
        .irst_n      (irst_n),
        .ivalid      (ivalid),
        .iwr_en      (iwr_en),
        .iaddr       (iaddr),
        .ifunct3     (ifunct3),
        .iwr_data    (iwr_data),
        .ord_data    (rd_le),
        .ostall      (stall_le),
        .omisaligned (mis_le)
    );

    riscv_dmem_ctrl #(
        .MP_DATA_WIDTH  (32),
        .MP_ADDR_WIDTH  (32),
        .MP_DEPTH_WORDS (DEPTH),
        .MP_ENDIANESS   (LP_BIG_ENDIAN)
    ) dut_be (
        .iclk        (iclk),
        .irst_n      (irst_n),
        .ivalid      (ivalid),
        .iwr_en      (iwr_en),
        .iaddr       (iaddr),
        .ifunct3     (ifunct3),
        .iwr_data    (iwr_data),
        .ord_data    (rd_be),
        .ostall      (stall_be),
        .omisaligned (mis_be)
    );

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    endfunction

    function automatic bit is_mis(input logic [31:0] a, input logic [2:0] f3);
        return (nbytes(f3) == 2 && a[0]) || (nbytes(f3) == 4 && a[1:0] != 2'b00);
    endfunction

    function automatic int wrap(input logic [31:0] a);
        return int'(a % 32'(NB));
    endfunction

    // Byte offset k of a word sits at bits 8k (little) or 8(3-k) (big).
    function automatic int bitpos(input int e, input int k);
        return (e != 0) ? 8 * (3 - k) : 8 * k;
    endfunction

    task automatic word_at(input int e, input logic [31:0] a, output logic [31:0] w,
                           output bit ok);
        int base;
        base = wrap(a) & ~3;
        w  = '0;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w[bitpos(e, k) +: 8] = mb[e][base + k];
            ok = ok && known[e][base + k];
        end
    endtask

    // Split-load result: accessed bytes laid out as if the access sat at offset 0.
    task automatic merged_at(input int e, input logic [31:0] a, input logic [2:0] f3,
                             output logic [31:0] w, output bit ok);
        w  = '0;
        ok = 1'b1;
        for (int p = 0; p < nbytes(f3); p++) begin
            w[bitpos(e, p) +: 8] = mb[e][wrap(a + 32'(p))];
            ok = ok && known[e][wrap(a + 32'(p))];
        end
    endtask

    task automatic mstore(input int e, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] d, input bit second);
        int n;
        int vb;
        n = nbytes(f3);
        for (int p = 0; p < n; p++) begin
            if (((int'(a[1:0]) + p) >= 4) == second) begin
                vb = (e != 0) ? n - 1 - p : p;
                mb[e][wrap(a + 32'(p))]    = d[8*vb +: 8];
                known[e][wrap(a + 32'(p))] = 1'b1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, required %08h", name, act, exp);
        end
    endtask

    task automatic cmp_dut(input int e, input logic [31:0] rd, input logic st, input logic ms);
        logic [31:0] w;
        bit          ok;
        bit          mis_now;
        string       tag;
        tag     = (e != 0) ? "be" : "le";
        mis_now = irst_n && ivalid && !second_beat && is_mis(iaddr, ifunct3);
        if (second_beat) merged_at(e, iaddr, ifunct3, w, ok);
        else             word_at(e, iaddr, w, ok);
        check({tag, ".ostall"}, {31'b0, st}, {31'b0, mis_now && EN});
        check({tag, ".omisaligned"}, {31'b0, ms}, {31'b0, mis_now});
        // Read data during the second beat of a store carries no meaning.
        if (ok && !(second_beat && iwr_en)) check({tag, ".ord_data"}, rd, w);
    endtask

    always @(negedge iclk) begin
        cmp_dut(0, rd_le, stall_le, mis_le);
        cmp_dut(1, rd_be, stall_be, mis_be);
    end

    task automatic access(input bit wr, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] d);
        bit mis;
        mis      = is_mis(a, f3);
        ivalid   = 1'b1;
        iwr_en   = wr;
        iaddr    = a;
        ifunct3  = f3;
        iwr_data = d;
        #2;
        fb_rd[0] = rd_le;    fb_rd[1] = rd_be;
        fb_stall[0] = stall_le; fb_stall[1] = stall_be;
        fb_mis[0] = mis_le;  fb_mis[1] = mis_be;
        @(posedge iclk);
        if (wr && (EN || !mis)) begin
            mstore(0, a, f3, d, 1'b0);
            mstore(1, a, f3, d, 1'b0);
        end
        #1;
        if (EN && mis) begin
            second_beat = 1'b1;
            #2;
            sb_rd[0] = rd_le;
            sb_rd[1] = rd_be;
            @(posedge iclk);
            if (wr) begin
                mstore(0, a, f3, d, 1'b1);
                mstore(1, a, f3, d, 1'b1);
            end
            #1;
            second_beat = 1'b0;
        end
        ivalid = 1'b0;
        iwr_en = 1'b0;
    endtask

    // Misaligned store with reset asserted right after its first beat.
    task automatic access_abort(input logic [31:0] a, input logic [31:0] d);
        ivalid   = 1'b1;
        iwr_en   = 1'b1;
        iaddr    = a;
        ifunct3  = 3'b010;
        iwr_data = d;
        @(posedge iclk);
        if (EN) begin
            mstore(0, a, 3'b010, d, 1'b0);
            mstore(1, a, 3'b010, d, 1'b0);
        end
        #1;
        irst_n = 1'b0;
        #1;
        ab_stall[0] = stall_le;
        ab_stall[1] = stall_be;
        @(posedge iclk);
        #1;
        ivalid = 1'b0;
        iwr_en = 1'b0;
        @(posedge iclk);
        #1;
        irst_n = 1'b1;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] le, output logic [31:0] be);
        ivalid  = 1'b0;
        iaddr   = a;
        ifunct3 = 3'b010;
        #2;
        le = rd_le;
        be = rd_be;
        @(posedge iclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        for (int e = 0; e < 2; e++)
            for (int i = 0; i < NB; i++) known[e][i] = 1'b0;
        #2;
        check("rst.le.ostall", {31'b0, stall_le}, 32'h0);
        check("rst.le.omisaligned", {31'b0, mis_le}, 32'h0);
        check("rst.be.ostall", {31'b0, stall_be}, 32'h0);
        check("rst.be.omisaligned", {31'b0, mis_be}, 32'h0);
        @(posedge iclk); #1;
        @(posedge iclk); #1;
        irst_n = 1'b1;
        @(posedge iclk); #1;

        access(1'b1, 32'h10, 3'b010, 32'hDEADBEEF);
        access(1'b0, 32'h10, 3'b010, 32'h0);
        check("t1.lw", fb_rd[0], 32'hDEADBEEF);
        check("t1.stall", {31'b0, fb_stall[0]}, 32'h0);

        access(1'b1, 32'h10, 3'b010, 32'h11223344);
        access(1'b1, 32'h13, 3'b000, 32'h000000AA);
        peek(32'h10, pa[0], pa[1]);
        check("t2.sb.le", pa[0], 32'hAA223344);
        check("t2.sb.be", pa[1], 32'h112233AA);

        access(1'b1, 32'h20, 3'b010, 32'h0);
        access(1'b1, 32'h22, 3'b001, 32'h0000BEEF);
        access(1'b0, 32'h20, 3'b010, 32'h0);
        check("t3.sh.be", fb_rd[1], 32'h0000BEEF);
        check("t3.sh.le", fb_rd[0], 32'hBEEF0000);

        access(1'b1, 32'h4, 3'b010, 32'h44332211);
        access(1'b1, 32'h8, 3'b010, 32'h88776655);
        access(1'b0, 32'h6, 3'b010, 32'h0);
        check("t4.mis", {31'b0, fb_mis[0]}, 32'h1);
`ifdef RISCV_DMEM_MISALIGN_EN
        check("t4.stall", {31'b0, fb_stall[0]}, 32'h1);
        check("t4.merge.le", sb_rd[0], 32'h66554433);
        check("t4.merge.be", sb_rd[1], 32'h22118877);
`else
        check("t4.stall", {31'b0, fb_stall[0]}, 32'h0);
        check("t4.raw.le", fb_rd[0], 32'h44332211);
`endif

        access(1'b1, 32'h5, 3'b010, 32'hCAFEF00D);
        check("t5.mis", {31'b0, fb_mis[0]}, 32'h1);
        peek(32'h4, pa[0], pa[1]);
        peek(32'h8, pb[0], pb[1]);
`ifdef RISCV_DMEM_MISALIGN_EN
        check("t5.lo.le", pa[0], 32'hFEF00D11);
        check("t5.hi.le", pb[0], 32'h887766CA);
`else
        check("t5.stall", {31'b0, fb_stall[0]}, 32'h0);
        check("t5.lo.le", pa[0], 32'h44332211);
        check("t5.hi.le", pb[0], 32'h88776655);
`endif

        access(1'b1, 32'h3C, 3'b010, 32'h0);
        access(1'b1, 32'h0, 3'b010, 32'h0);
        access(1'b1, 32'h3E, 3'b010, 32'h12345678);
        peek(32'h3C, pa[0], pa[1]);
        peek(32'h0, pb[0], pb[1]);
`ifdef RISCV_DMEM_MISALIGN_EN
        check("t6.top.le", pa[0], 32'h56780000);
        check("t6.w0.le", pb[0], 32'h00001234);
`else
        check("t6.top.le", pa[0], 32'h0);
        check("t6.w0.le", pb[0], 32'h0);
`endif

        access(1'b1, 32'h4000_0030, 3'b010, 32'h0BADF00D);
        peek(32'h30, pa[0], pa[1]);
        check("t7.alias.le", pa[0], 32'h0BADF00D);
        check("t7.alias.be", pa[1], 32'h0BADF00D);

        access(1'b1, 32'h18, 3'b010, 32'h01020304);
        access(1'b1, 32'h1C, 3'b010, 32'h05060708);
        access(1'b1, 32'h19, 3'b001, 32'h00001357);
        access(1'b0, 32'h18, 3'b010, 32'h0);
        access(1'b1, 32'h1B, 3'b001, 32'h00002468);
        access(1'b0, 32'h1B, 3'b001, 32'h0);
        access(1'b0, 32'h19, 3'b101, 32'h0);
        access(1'b0, 32'h1A, 3'b011, 32'h0);
        access(1'b0, 32'h1C, 3'b011, 32'h0);
        for (int i = 0; i < 8; i++) access(1'b0, 32'h18 + 32'(i), 3'b100, 32'h0);

        access(1'b1, 32'h2C, 3'b010, 32'h0);
        access(1'b1, 32'h30, 3'b010, 32'h0);
        access_abort(32'h2E, 32'hA1B2C3D4);
        check("t9.rst.stall.le", {31'b0, ab_stall[0]}, 32'h0);
        check("t9.rst.stall.be", {31'b0, ab_stall[1]}, 32'h0);
        peek(32'h2C, pa[0], pa[1]);
        peek(32'h30, pb[0], pb[1]);
        check("t9.hi.le", pb[0], 32'h0);
`ifdef RISCV_DMEM_MISALIGN_EN
        check("t9.lo.le", pa[0], 32'hC3D40000);
        check("t9.lo.be", pa[1], 32'h0000A1B2);
`else
        check("t9.lo.le", pa[0], 32'h0);
`endif
        access(1'b0, 32'h2E, 3'b010, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
